vga2_sdram_arb: RTL
===================

# vga2_sdram_arb

Shares the single burst-read SDRAM port between up to four `vga2_readmem` instances, such as background, sprite and cursor layers. Each client drives the same request/ready/address and rvalid/raddress/rdata/complete handshake it would present to the SDRAM directly. The arbiter grants one client per burst and holds the grant until that burst completes. It routes the returned beats only to the owning client and flags protocol errors.

## Interface
Parameters:
- `NUM_CLIENTS`, default 2: number of requesters, legal range 1..4.

Ports:
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `client_request`  in  NUM_CLIENTS  per-client burst request.
- `client_address`  in  26*NUM_CLIENTS  per-client burst address; client i occupies bits [26i+25:26i].
- `client_ready`  out  NUM_CLIENTS  one-cycle pulse meaning client i's request has been accepted.
- `client_rvalid`  out  NUM_CLIENTS  read beat valid, routed to the owning client only.
- `client_raddress`  out  26  broadcast copy of `sdram_raddress`.
- `client_rdata`  out  32  broadcast copy of `sdram_rdata`.
- `client_complete`  out  NUM_CLIENTS  burst complete, routed to the owning client only.
- `sdram_request`  out  1  request to the SDRAM.
- `sdram_ready`  in  1  SDRAM accepts the request this cycle.
- `sdram_address`  out  26  latched burst address.
- `sdram_rvalid`  in  1  read beat from the SDRAM.
- `sdram_raddress`  in  26  address of the read beat.
- `sdram_rdata`  in  32  read data.
- `sdram_complete`  in  1  last beat of the burst.
- `arb_owner`  out  2  index of the current or last grant.
- `arb_busy`  out  1  high whenever the state is not IDLE.
- `arb_error`  out  1  sticky protocol-error flag.

## Operation
- States are IDLE, ISSUE and BURST.
- IDLE:
  - If any `client_request` is high, select a winner (see Configuration).
  - Latch the winner's address into `sdram_address` and its index into `arb_owner`.
  - Register `client_ready[winner]` = 1 and `sdram_request` = 1, then go to ISSUE.
- ISSUE:
  - Hold `sdram_request` high and `sdram_address` stable.
  - When `sdram_request && sdram_ready`, drop `sdram_request` on the next cycle and go to BURST.
  - `client_ready` is high only in the first ISSUE cycle, regardless of how long ISSUE lasts.
- BURST:
  - Wait for `sdram_complete`, then go to IDLE.
  - Update the round-robin pointer to `arb_owner`+1 modulo NUM_CLIENTS.
- Routing, combinational, whenever state != IDLE:
  - `client_rvalid[owner]` = `sdram_rvalid`.
  - `client_complete[owner]` = `sdram_complete`.
  - All other clients see 0 on both signals.
- Routing in IDLE: all `client_rvalid` and `client_complete` bits are 0.
- Error conditions; each sets `arb_error` until reset:
  - `sdram_rvalid` or `sdram_complete` high while in IDLE. The beat is dropped.
  - `sdram_complete` high while in ISSUE before the request has been accepted.
- Requests that arrive while the arbiter is busy are not lost. Clients hold `client_request` until they see `client_ready`.
- The owning client's request line is ignored until the state returns to IDLE. This covers the cycle after `client_ready`, in which the client deasserts its request.

## Timing
- Reset (asynchronous, `reset_n` = 0):
  - state = IDLE, round-robin pointer = 0, `arb_owner` = 0.
  - `sdram_request`, `client_ready`, `arb_busy` and `arb_error` = 0.
  - `sdram_address` = 0.
- Reset mid-burst: the arbiter returns to IDLE immediately. Remaining SDRAM beats after reset release set `arb_error`.
- Grant latency:
  - Request seen in IDLE at cycle N.
  - `sdram_request` and `client_ready` are high at N+1.
  - If `sdram_ready` is high at N+1, the state is BURST at N+2.
- Turnaround: `sdram_complete` at cycle M puts the state in IDLE at M+1. A new `sdram_request` can be issued at M+2.
- Routed outputs have zero added latency relative to the SDRAM inputs.
- Simultaneous `sdram_complete` and `sdram_rvalid` in BURST: the beat is routed and the burst ends in the same cycle.
- NUM_CLIENTS = 1: arbitration is trivial. The state machine and error checks still apply.

## Configuration
- `VGA2_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, where the lowest-index requester always wins. Use this to keep client 0, the display layer, starvation-free.
  - Undefined (default): round-robin. The search starts at the pointer, so after client i is served, client i+1 (wrapping) has the highest priority.

## Test plan
- Single client: client 0 requests 0x0000040 and the SDRAM holds `sdram_ready` low for 3 cycles.
  - `sdram_request` stays high for 4 cycles and `client_ready[0]` pulses once.
  - 16 beats appear on `client_rvalid[0]` only, then `client_complete[0]`.
- Contention: clients 0 and 1 request on the same cycle, 3 bursts each, round-robin build.
  - Grant order is 0,1,0,1,0,1.
  - With `VGA2_ARB_FIXED_PRIO_EN` the order is 0,0,0,1,1,1.
- Request during a burst: client 1 requests mid-BURST of client 0.
  - Client 1 is granted exactly 2 cycles after client 0's `sdram_complete`.
  - No beat from client 0's burst reaches `client_rvalid[1]`.
- Stray data: pulse `sdram_rvalid` in IDLE.
  - `arb_error` = 1 and stays high.
  - All `client_rvalid` bits = 0.
- Reset mid-burst: assert `reset_n` = 0 after beat 5.
  - All outputs take their reset values asynchronously and the state is IDLE.
  - After release, a new request is granted normally.

Source files
------------

// File: rtl/vga2_sdram_arb_if.sv
// Bus bundle between up to four vga2_readmem clients, the burst arbiter and
// the shared SDRAM read port. The master modport is the arbiter's view; the
// slave modport is the view of the clients plus the SDRAM.
interface vga2_sdram_arb_if #(
    parameter int unsigned NUM_CLIENTS = 2
);
    logic [NUM_CLIENTS-1:0]    client_request;
    logic [26*NUM_CLIENTS-1:0] client_address;
    logic [NUM_CLIENTS-1:0]    client_ready;
    logic [NUM_CLIENTS-1:0]    client_rvalid;
    logic [25:0]               client_raddress;
    logic [31:0]               client_rdata;
    logic [NUM_CLIENTS-1:0]    client_complete;

    logic                      sdram_request;
    logic                      sdram_ready;
    logic [25:0]               sdram_address;
    logic                      sdram_rvalid;
    logic [25:0]               sdram_raddress;
    logic [31:0]               sdram_rdata;
    logic                      sdram_complete;

    modport master (
        input  client_request, client_address,
        output client_ready, client_rvalid, client_raddress, client_rdata, client_complete,
        output sdram_request, sdram_address,
        input  sdram_ready, sdram_rvalid, sdram_raddress, sdram_rdata, sdram_complete
    );

    modport slave (
        output client_request, client_address,
        input  client_ready, client_rvalid, client_raddress, client_rdata, client_complete,
        input  sdram_request, sdram_address,
        output sdram_ready, sdram_rvalid, sdram_raddress, sdram_rdata, sdram_complete
    );
endinterface

// File: rtl/vga2_sdram_arb.sv
// Burst arbiter sharing one SDRAM read port between NUM_CLIENTS (1..4)
// vga2_readmem clients. One grant per burst, held until sdram_complete;
// returned beats are routed to the owning client only, and protocol
// violations set a sticky arb_error.
// Build option: define VGA2_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins); default is round-robin starting at the pointer.
module vga2_sdram_arb #(
    parameter int unsigned NUM_CLIENTS = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    vga2_sdram_arb_if.master      bus,
    output logic [1:0]            arb_owner,
    output logic                  arb_busy,
    output logic                  arb_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t                 state;
    logic [1:0]             rr_ptr;
    logic [NUM_CLIENTS-1:0] ready_q;
    logic                   req_q;
    logic [25:0]            addr_q;

    logic                   win_found;
    logic [1:0]             win_idx;
    logic [1:0]             cand;
    logic [25:0]            win_addr;
    logic [1:0]             next_ptr;

    // Pick the winning requester for the next burst.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
`ifdef VGA2_ARB_FIXED_PRIO_EN
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            if (!win_found && bus.client_request[i]) begin
                win_found = 1'b1;
                win_idx   = 2'(i);
            end
        end
`else
        // Search NUM_CLIENTS slots starting at the pointer; the inner loop turns
        // the rotated index into constant bit selects.
        for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
            cand = 2'((32'(rr_ptr) + k) % NUM_CLIENTS);
            for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
                if (!win_found && (2'(i) == cand) && bus.client_request[i]) begin
                    win_found = 1'b1;
                    win_idx   = cand;
                end
            end
        end
`endif
    end

    // Mux the winner's burst address.
    always_comb begin
        win_addr = '0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            if (2'(i) == win_idx) begin
                win_addr = bus.client_address[26*i +: 26];
            end
        end
    end

    assign next_ptr = 2'((32'(arb_owner) + 1) % NUM_CLIENTS);

    // Grant state machine with registered handshake outputs and error flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            arb_owner <= '0;
            req_q     <= 1'b0;
            ready_q   <= '0;
            addr_q    <= '0;
            arb_busy  <= 1'b0;
            arb_error <= 1'b0;
        end else begin
            ready_q <= '0;
            case (state)
                IDLE: begin
                    if (bus.sdram_rvalid || bus.sdram_complete) begin
                        arb_error <= 1'b1;
                    end
                    if (win_found) begin
                        addr_q    <= win_addr;
                        arb_owner <= win_idx;
                        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
                            ready_q[i] <= (2'(i) == win_idx);
                        end
                        req_q     <= 1'b1;
                        arb_busy  <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.sdram_complete && !bus.sdram_ready) begin
                        arb_error <= 1'b1;
                    end
                    if (req_q && bus.sdram_ready) begin
                        req_q <= 1'b0;
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (bus.sdram_complete) begin
                        rr_ptr   <= next_ptr;
                        arb_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    req_q    <= 1'b0;
                    arb_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Route read beats and completion to the owner only, never while idle.
    always_comb begin
        bus.client_rvalid   = '0;
        bus.client_complete = '0;
        if (state != IDLE) begin
            for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
                if (2'(i) == arb_owner) begin
                    bus.client_rvalid[i]   = bus.sdram_rvalid;
                    bus.client_complete[i] = bus.sdram_complete;
                end
            end
        end
    end

    assign bus.client_ready    = ready_q;
    assign bus.sdram_request   = req_q;
    assign bus.sdram_address   = addr_q;
    assign bus.client_raddress = bus.sdram_raddress;
    assign bus.client_rdata    = bus.sdram_rdata;

endmodule
